// File: rtl/filter_peak_detector_pkg.sv
// Shared settings for the filter peak detector: sample/timestamp sizes,
// pulse timing constants and the detector FSM encoding.
package filter_peak_detector_pkg;

  localparam int SIZE_FILTER_DATA  = 16;
  localparam int SIZE_TEST_COUNTER = 16;

  // Trapezoid rise (k_2) and flat-top (l_2) lengths of the v2 filter.
  localparam int K_2 = 5;
  localparam int L_2 = 5;

  localparam int PEAK_HOLDOFF   = K_2 + L_2;
  localparam int PEAK_MIN_WIDTH = 2;
  localparam int PEAK_WID_W     = 8;

  typedef enum logic [1:0] {
    PK_IDLE    = 2'd0,
    PK_RISE    = 2'd1,
    PK_HOLDOFF = 2'd2
  } peak_state_t;

endpackage

// File: rtl/filter_peak_detector_peak_ts_counter.sv
// Sample timestamp: wrapping TS_W counter that advances once per valid
// filter sample; the current value belongs to the sample being presented.
module peak_ts_counter
  import filter_peak_detector_pkg::*;
#(
  parameter int TS_W = SIZE_TEST_COUNTER
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en,
  output logic [TS_W-1:0] ts
);

  logic [TS_W-1:0] ts_q;
  logic [TS_W-1:0] ts_d;

  always_comb begin
    ts_d = ts_q;
    if (en) begin
      ts_d = ts_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_d;
    end
  end

  assign ts = ts_q;

endmodule

// File: rtl/filter_peak_detector.sv
// Peak detector for the trapezoidal filter output: qualifies above-threshold
// pulses, reports peak amplitude/time and applies a holdoff dead-time.
// Optional pile-up rejection: define FILTER_PEAK_DETECTOR_PILEUP_REJECT_EN.
module filter_peak_detector
  import filter_peak_detector_pkg::*;
#(
  parameter int DATA_W    = SIZE_FILTER_DATA,
  parameter int TS_W      = SIZE_TEST_COUNTER,
  parameter int HOLDOFF   = PEAK_HOLDOFF,
  parameter int MIN_WIDTH = PEAK_MIN_WIDTH,
  parameter int WID_W     = PEAK_WID_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic signed [DATA_W-1:0] filter_data,
  input  logic                     filter_valid,
  input  logic        [DATA_W-2:0] threshold,
  output logic                     peak_valid,
  output logic signed [DATA_W-1:0] peak_amp,
  output logic        [TS_W-1:0]   peak_time,
  output logic                     busy
);

  localparam int HC_W = $clog2(HOLDOFF + 2);
  localparam logic [HC_W-1:0]  HOLD_INIT = HC_W'(HOLDOFF);
  localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(1);
  localparam logic [WID_W-1:0] WID_MIN   = WID_W'(MIN_WIDTH);
  localparam logic [WID_W-1:0] WID_ONE   = WID_W'(1);

  function automatic logic [WID_W-1:0] sat_inc(input logic [WID_W-1:0] w);
    return (&w) ? w : w + 1'b1;
  endfunction

  peak_state_t               state_q, state_d;
  logic signed [DATA_W-1:0]  thr_q, thr_d;
  logic signed [DATA_W-1:0]  max_q, max_d;
  logic        [TS_W-1:0]    t_max_q, t_max_d;
  logic        [WID_W-1:0]   width_q, width_d;
  logic        [HC_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic                      peak_valid_q, peak_valid_d;
  logic signed [DATA_W-1:0]  peak_amp_q, peak_amp_d;
  logic        [TS_W-1:0]    peak_time_q, peak_time_d;
  logic                      busy_q, busy_d;
`ifdef FILTER_PEAK_DETECTOR_PILEUP_REJECT_EN
  logic                      pile_q, pile_d;
`endif

  logic        [TS_W-1:0]    ts;
  logic signed [DATA_W-1:0]  thr_ext;
  logic                      above_new;
  logic                      above_lat;
  logic                      qualify;
  logic                      hold_exit;
  logic                      emit;

  peak_ts_counter #(
    .TS_W (TS_W)
  ) u_ts (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (filter_valid),
    .ts      (ts)
  );

  // Threshold is unsigned on the port; zero-extend so the compare stays signed.
  assign thr_ext   = $signed({1'b0, threshold});
  assign above_new = filter_data > thr_ext;
  assign above_lat = filter_data > thr_q;

  always_comb begin : next_state
    state_d    = state_q;
    thr_d      = thr_q;
    max_d      = max_q;
    t_max_d    = t_max_q;
    width_d    = width_q;
    hold_cnt_d = hold_cnt_q;
    qualify    = 1'b0;
    hold_exit  = 1'b0;
`ifdef FILTER_PEAK_DETECTOR_PILEUP_REJECT_EN
    pile_d     = pile_q;
`endif
    if (filter_valid) begin
      unique case (state_q)
        PK_IDLE: begin
          if (above_new) begin
            thr_d   = thr_ext;
            max_d   = filter_data;
            t_max_d = ts;
            width_d = WID_ONE;
            state_d = PK_RISE;
          end
        end
        PK_RISE: begin
          if (above_lat) begin
            width_d = sat_inc(width_q);
            // Strict compare keeps the earliest sample on ties.
            if (filter_data > max_q) begin
              max_d   = filter_data;
              t_max_d = ts;
            end
          end else if (width_q >= WID_MIN) begin
            qualify    = 1'b1;
            hold_cnt_d = HOLD_INIT;
            state_d    = (HOLDOFF == 0) ? PK_IDLE : PK_HOLDOFF;
`ifdef FILTER_PEAK_DETECTOR_PILEUP_REJECT_EN
            pile_d     = 1'b0;
`endif
          end else begin
            state_d = PK_IDLE;
          end
        end
        PK_HOLDOFF: begin
          hold_cnt_d = hold_cnt_q - 1'b1;
`ifdef FILTER_PEAK_DETECTOR_PILEUP_REJECT_EN
          if (above_lat) begin
            pile_d = 1'b1;
          end
`endif
          if (hold_cnt_q == HOLD_LAST) begin
            hold_exit = 1'b1;
            state_d   = PK_IDLE;
          end
        end
        default: begin
          state_d = PK_IDLE;
        end
      endcase
    end
  end

  always_comb begin : outputs
`ifdef FILTER_PEAK_DETECTOR_PILEUP_REJECT_EN
    // Event waits for a clean holdoff window; the exit sample also counts.
    if (HOLDOFF == 0) begin
      emit = qualify;
    end else begin
      emit = hold_exit && !pile_q && !above_lat;
    end
`else
    emit = qualify;
`endif
    peak_valid_d = emit;
    peak_amp_d   = emit ? max_q   : peak_amp_q;
    peak_time_d  = emit ? t_max_q : peak_time_q;
    busy_d       = (state_d != PK_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= PK_IDLE;
      thr_q        <= '0;
      max_q        <= '0;
      t_max_q      <= '0;
      width_q      <= '0;
      hold_cnt_q   <= '0;
      peak_valid_q <= 1'b0;
      peak_amp_q   <= '0;
      peak_time_q  <= '0;
      busy_q       <= 1'b0;
`ifdef FILTER_PEAK_DETECTOR_PILEUP_REJECT_EN
      pile_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      thr_q        <= thr_d;
      max_q        <= max_d;
      t_max_q      <= t_max_d;
      width_q      <= width_d;
      hold_cnt_q   <= hold_cnt_d;
      peak_valid_q <= peak_valid_d;
      peak_amp_q   <= peak_amp_d;
      peak_time_q  <= peak_time_d;
      busy_q       <= busy_d;
`ifdef FILTER_PEAK_DETECTOR_PILEUP_REJECT_EN
      pile_q       <= pile_d;
`endif
    end
  end

  assign peak_valid = peak_valid_q;
  assign peak_amp   = peak_amp_q;
  assign peak_time  = peak_time_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_filter_peak_detector.sv
// Bench for filter_peak_detector: table of hand-derived vectors, directed
// corner sequences and random traffic against a pulse-level reference model.
module tb_filter_peak_detector;

`ifdef FILTER_PEAK_DETECTOR_PILEUP_REJECT_EN
  localparam bit PU = 1'b1;
`else
  localparam bit PU = 1'b0;
`endif
  localparam int HOLD = 10;
  localparam int MINW = 2;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic signed [15:0] filter_data = '0;
  logic               filter_valid = 1'b0;
  logic        [14:0] threshold = '0;
  logic               peak_valid;
  logic signed [15:0] peak_amp;
  logic        [15:0] peak_time;
  logic               busy;

  filter_peak_detector dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .filter_data  (filter_data),
    .filter_valid (filter_valid),
    .threshold    (threshold),
    .peak_valid   (peak_valid),
    .peak_amp     (peak_amp),
    .peak_time    (peak_time),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pv_count = 0;
  int last_amp = 0;
  int last_time = 0;

  // Reference model: pulse-level view of the sample stream.
  int m_ts = 0;
  bit m_in = 0;
  int m_len = 0;
  int m_max = 0;
  int m_tmax = 0;
  int m_thr = 0;
  int m_dead = 0;
  bit m_pend = 0;
  bit m_piled = 0;
  int m_pamp = 0;
  int m_ptime = 0;
  bit e_pv = 0;
  int e_amp = 0;
  int e_time = 0;
  bit e_busy = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_emit(input int amp, input int t);
    e_pv = 1'b1;
    e_amp = amp;
    e_time = t;
  endfunction

  function automatic void model_step(input bit rn, input bit v, input int d, input int th);
    int s_ts;
    e_pv = 1'b0;
    if (!rn) begin
      m_ts = 0; m_in = 0; m_len = 0; m_max = 0; m_tmax = 0; m_thr = 0;
      m_dead = 0; m_pend = 0; m_piled = 0;
      e_amp = 0; e_time = 0; e_busy = 0;
      return;
    end
    if (v) begin
      s_ts = m_ts;
      m_ts = (m_ts + 1) % 65536;
      if (m_dead > 0) begin
        if (d > m_thr) m_piled = 1'b1;
        m_dead--;
        if (m_dead == 0 && m_pend) begin
          if (!m_piled) model_emit(m_pamp, m_ptime);
          m_pend = 1'b0;
        end
      end else if (m_in) begin
        if (d > m_thr) begin
          m_len++;
          if (d > m_max) begin
            m_max = d;
            m_tmax = s_ts;
          end
        end else begin
          m_in = 1'b0;
          if (m_len >= MINW) begin
            if (!PU || HOLD == 0) model_emit(m_max, m_tmax);
            else begin
              m_pend = 1'b1; m_piled = 1'b0; m_pamp = m_max; m_ptime = m_tmax;
            end
            m_dead = HOLD;
          end
        end
      end else if (d > th) begin
        m_in = 1'b1; m_len = 1; m_max = d; m_tmax = s_ts; m_thr = th;
      end
    end
    e_busy = m_in || (m_dead > 0);
  endfunction

  task automatic step(input bit rn, input bit v, input int d, input int th);
    reset_n = rn;
    filter_valid = v;
    filter_data = d[15:0];
    threshold = th[14:0];
    @(posedge clk);
    model_step(rn, v, d, th);
    #1;
    if (peak_valid === 1'b1) begin
      pv_count++;
      last_amp = int'(peak_amp);
      last_time = int'(peak_time);
    end
    chk("model_peak_valid", int'(peak_valid), int'(e_pv));
    chk("model_peak_amp", int'(peak_amp), e_amp);
    chk("model_peak_time", int'(peak_time), e_time);
    chk("model_busy", int'(busy), int'(e_busy));
  endtask

  task automatic idle(input int n, input int th);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 0, th);
  endtask

  typedef struct {
    bit rn; bit v; int d; int th;
    bit epv; int eamp; int etime; bit ebusy;
  } vec_t;

  vec_t tbl[20];
  int tri_w[9] = '{0, 50, 150, 300, 450, 300, 150, 50, 0};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int emit_k;
    int first_ts;
    int base;

    // Basic triangle, expectations derived by hand.
    emit_k = PU ? 17 : 7;
    tbl[0] = '{rn: 1'b0, v: 1'b0, d: 0, th: 100, epv: 1'b0, eamp: 0, etime: 0, ebusy: 1'b0};
    for (int r = 1; r < 20; r++) begin
      k = r - 1;
      tbl[r].rn = 1'b1;
      tbl[r].v = 1'b1;
      tbl[r].d = (k < 9) ? tri_w[k] : 0;
      tbl[r].th = 100;
      tbl[r].epv = (k == emit_k);
      tbl[r].eamp = (k >= emit_k) ? 450 : 0;
      tbl[r].etime = (k >= emit_k) ? 4 : 0;
      tbl[r].ebusy = (k >= 2 && k <= 16);
    end

    step(1'b0, 1'b0, 0, 100);
    for (int r = 0; r < 20; r++) begin
      step(tbl[r].rn, tbl[r].v, tbl[r].d, tbl[r].th);
      chk("tbl_peak_valid", int'(peak_valid), int'(tbl[r].epv));
      chk("tbl_peak_amp", int'(peak_amp), tbl[r].eamp);
      chk("tbl_peak_time", int'(peak_time), tbl[r].etime);
      chk("tbl_busy", int'(busy), int'(tbl[r].ebusy));
    end

    // Narrow single-sample pulse.
    pv_count = 0;
    step(1'b1, 1'b1, 0, 100);
    step(1'b1, 1'b1, 200, 100);
    step(1'b1, 1'b1, 0, 100);
    chk("narrow_busy", int'(busy), 0);
    idle(12, 100);
    chk("narrow_no_peak", pv_count, 0);

    // Plateau: tie keeps the first sample.
    pv_count = 0;
    first_ts = m_ts;
    step(1'b1, 1'b1, 300, 100);
    step(1'b1, 1'b1, 300, 100);
    step(1'b1, 1'b1, 120, 100);
    step(1'b1, 1'b1, 0, 100);
    idle(14, 100);
    chk("plateau_count", pv_count, 1);
    chk("plateau_amp", last_amp, 300);
    chk("plateau_time", last_time, first_ts);

    // Negative and threshold-equal samples never trigger.
    pv_count = 0;
    step(1'b1, 1'b1, -500, 100);
    chk("neg_busy", int'(busy), 0);
    step(1'b1, 1'b1, 100, 100);
    chk("eq_thr_busy", int'(busy), 0);
    step(1'b1, 1'b1, -32768, 100);
    chk("min_busy", int'(busy), 0);
    chk("neg_no_peak", pv_count, 0);

    // Full-scale positive peak.
    step(1'b1, 1'b1, 200, 100);
    step(1'b1, 1'b1, 32767, 100);
    step(1'b1, 1'b1, 0, 100);
    idle(14, 100);
    chk("fullscale_count", pv_count, 1);
    chk("fullscale_amp", last_amp, 32767);

    // Gapped valid triangle after reset.
    step(1'b0, 1'b0, 0, 100);
    pv_count = 0;
    for (int i = 0; i < 18; i++) begin
      step(1'b1, 1'b1, (i < 9) ? tri_w[i] : 0, 100);
      if (i == 7) chk("gap_emit_timing", int'(peak_valid), PU ? 0 : 1);
      for (int g = 0; g < 3; g++) step(1'b1, 1'b0, 999, 100);
    end
    step(1'b1, 1'b1, 0, 100);
    chk("gap_count", pv_count, 1);
    chk("gap_amp", last_amp, 450);
    chk("gap_time", last_time, 4);

    // Pile-up: second triangle inside holdoff, third one well after.
    step(1'b0, 1'b0, 0, 100);
    pv_count = 0;
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, tri_w[i], 100);
    idle(3, 100);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, tri_w[i], 100);
    chk("pileup_first", pv_count, PU ? 0 : 1);
    idle(11, 100);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, tri_w[i], 100);
    idle(20, 100);
    chk("pileup_total", pv_count, PU ? 1 : 2);

    // Reset during RISE drops the pulse; timestamps restart at 0.
    pv_count = 0;
    step(1'b1, 1'b1, 0, 100);
    step(1'b1, 1'b1, 200, 100);
    step(1'b1, 1'b1, 300, 100);
    chk("rst_mid_busy_before", int'(busy), 1);
    step(1'b0, 1'b1, 400, 100);
    chk("rst_mid_busy", int'(busy), 0);
    idle(3, 100);
    chk("rst_mid_no_peak", pv_count, 0);
    step(1'b0, 1'b0, 0, 100);
    base = pv_count;
    step(1'b1, 1'b1, 200, 100);
    step(1'b1, 1'b1, 300, 100);
    step(1'b1, 1'b1, 0, 100);
    idle(14, 100);
    chk("rst_ts_count", pv_count - base, 1);
    chk("rst_ts_time", last_time, 1);

    // Random traffic against the model.
    begin
      int th_r;
      int d_r;
      int sel;
      th_r = 100;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 39) == 0) th_r = ($urandom_range(0, 15) == 0) ? 32767 : int'($urandom_range(0, 300));
        sel = int'($urandom_range(0, 99));
        if (sel < 55) d_r = int'($urandom_range(0, 200)) - 50;
        else if (sel < 92) d_r = int'($urandom_range(100, 600));
        else if (sel < 96) d_r = (sel[0]) ? 32767 : -32768;
        else d_r = int'($urandom_range(0, 65535)) - 32768;
        step(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 7), d_r, th_r);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
